// File: rtl/pret_pkg.sv
// Shared types and helpers for the pret stochastic decoder: FSM states and
// power-of-two arithmetic on the beat count.
package pret_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // Index of the highest set bit; exact log2 when v is a power of two.
    function automatic logic [4:0] log2(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pret_sc_decoder_sc_acc.sv
// One channel of the decoder: ones counter plus a saturating left-align
// stage that scales the count from 2^k_eff beats up to W bits.
module sc_acc #(
    parameter  int W  = 8,
    localparam int PW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    input  logic [PW-1:0] k_eff,
    output logic [W-1:0]  b_out
);

    logic [W:0] acc_reg;
    logic [W:0] sum;
    logic [W:0] shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= sum;
        end
    end

    // The output already includes the current beat so the top can capture
    // the result on the terminating beat itself.
    always_comb begin
        sum     = acc_reg + {{W{1'b0}}, (en & bit_in)};
        shifted = sum << (PW'(W) - k_eff);
        b_out   = shifted[W] ? {W{1'b1}} : shifted[W-1:0];
    end

endmodule

// File: rtl/pret_sc_decoder.sv
// N-channel stochastic-to-binary decoder that counts ones over 2^k valid
// beats, with early termination at the next power-of-two beat boundary.
module pret_sc_decoder
    import pret_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 8,
    localparam int PW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] prec,
    input  logic          X_valid,
    input  logic [N-1:0]  X,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  Bxs [N-1:0],
    output logic [PW-1:0] k_out
);

    state_t        state_reg;
    logic [PW-1:0] kt_reg;
    logic [W:0]    cnt_reg;
    logic          stop_pend_reg;

    logic [W:0]    cnt_next;
    logic [PW-1:0] kt_clamped;
    logic [PW-1:0] k_eff;
    logic          beat;
    logic          term;
    logic          clr;
    logic [W-1:0]  b_all [N-1:0];

    always_comb begin
        beat       = (state_reg == RUN) && X_valid;
        clr        = (state_reg == IDLE) && start;
        cnt_next   = cnt_reg + 1'b1;
        kt_clamped = ((prec == '0) || (prec > PW'(W))) ? PW'(W) : prec;
        k_eff      = PW'(log2(32'(cnt_next)));
        term       = beat && ((cnt_next == ((W + 1)'(1) << kt_reg)) ||
                              ((stop_pend_reg || stop) && is_pow2(32'(cnt_next))));
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            sc_acc #(.W(W)) u_acc (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr),
                .en     (beat),
                .bit_in (X[gi]),
                .k_eff  (k_eff),
                .b_out  (b_all[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            kt_reg        <= '0;
            cnt_reg       <= '0;
            stop_pend_reg <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            k_out         <= '0;
            for (int i = 0; i < N; i++) Bxs[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        kt_reg        <= kt_clamped;
                        cnt_reg       <= '0;
                        stop_pend_reg <= 1'b0;
                        busy          <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (stop) stop_pend_reg <= 1'b1;
                    if (beat) begin
                        cnt_reg <= cnt_next;
                        if (term) begin
                            k_out     <= k_eff;
                            done      <= 1'b1;
                            state_reg <= DONE;
                            for (int i = 0; i < N; i++) Bxs[i] <= b_all[i];
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
